// File: rtl/udar_ctrl_mc.sv
// udar_ctrl_mc -- multi-channel UDAR host-protocol controller.
//
// Parses a byte-framed command stream from the serial rx engine. It writes
// NUM_SERVO servo position registers under an XOR checksum and starts the
// ultrasonic ranging unit. Every reply goes back through the serial tx engine.
//
// Ports:
//   clk, rst_i          system clock, asynchronous active-high reset
//   rx_data/rx_valid    received byte + one-cycle strobe
//   tx_data/tx_send     byte to transmit + one-cycle request (registered)
//   tx_busy             transmitter busy, rises <= 1 cycle after tx_send
//   pos                 channel k at [k*POS_LEN +: POS_LEN]
//   meas_en             one-cycle ranging start pulse
//   meas_done/meas_len  ranging result valid + value
//   frame_err           one-cycle pulse on every NACK
//
// Frames (host -> controller):
//   00                     re-init all channels, reply AA
//   03 ch val.. sum        servo write, sum = XOR of all preceding bytes, reply AB
//   0C                     ranging, reply AE len.. xor  (or EF on timeout)
//   anything bad           reply EE + frame_err

// One servo position register. init has priority over a channel write.
module udar_ctrl_mc_ch #(
  parameter int POS_LEN   = 8,
  parameter int POS_RESET = 150
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               init,
  input  logic               wr_en,
  input  logic [POS_LEN-1:0] wr_val,
  output logic [POS_LEN-1:0] pos
);
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i)      pos <= POS_LEN'(POS_RESET);
    else if (init)  pos <= POS_LEN'(POS_RESET);
    else if (wr_en) pos <= wr_val;
  end
endmodule

module udar_ctrl_mc #(
  parameter int NUM_SERVO = 4,
  parameter int POS_LEN   = 8,
  parameter int POS_RESET = 150,
  parameter int CAP_LEN   = 16,
  parameter int FRAME_TO  = 50000,
  parameter int MEAS_TO   = 2000000,
  parameter int TO_LEN    = 22
) (
  input  logic                         clk,
  input  logic                         rst_i,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic [7:0]                   tx_data,
  output logic                         tx_send,
  input  logic                         tx_busy,
  output logic [NUM_SERVO*POS_LEN-1:0] pos,
  output logic                         meas_en,
  input  logic                         meas_done,
  input  logic [CAP_LEN-1:0]           meas_len,
  output logic                         frame_err
);
  localparam int POS_BYTES = (POS_LEN + 7) / 8;
  localparam int VAL_W     = POS_BYTES * 8;
  localparam int CAP_BYTES = CAP_LEN / 8;
  localparam int REPLY_N   = CAP_BYTES + 2;        // longest reply (ranging)
  localparam int IW        = $clog2(REPLY_N);
  localparam int RW        = $clog2(REPLY_N + 1);
  localparam int VW        = (POS_BYTES > 1) ? $clog2(POS_BYTES + 1) : 1;

  localparam logic [TO_LEN-1:0] FRAME_TO_C = TO_LEN'(FRAME_TO);
  localparam logic [TO_LEN-1:0] MEAS_TO_C  = TO_LEN'(MEAS_TO);
  localparam logic [7:0]        NS8        = 8'(NUM_SERVO);
  localparam logic [VW-1:0]     VLAST      = VW'(POS_BYTES - 1);

  typedef enum logic [3:0] {
    BOOT, IDLE, SRV_CH, SRV_VAL, SRV_SUM,
    MEAS_TRIG, MEAS_WAIT, NACK, TX_LOAD, TX_WAIT
  } state_t;

  state_t                       state, state_nxt;
  logic [TO_LEN-1:0]            cnt, cnt_nxt;
  logic [7:0]                   csum, csum_nxt;
  logic [7:0]                   ch, ch_nxt;
  logic [VAL_W-1:0]             val, val_nxt;
  logic [VW-1:0]                vcnt, vcnt_nxt;
  logic [REPLY_N-1:0][7:0]      rbuf, rbuf_nxt, mbuf;
  logic [IW-1:0]                idx, idx_nxt;
  logic [RW-1:0]                rem, rem_nxt;
  logic                         skip, skip_nxt;
  logic [7:0]                   tx_data_nxt;
  logic                         tx_send_nxt, meas_en_nxt, frame_err_nxt;
  logic                         init_all, wr_srv;
  logic                         reply_one;
  logic [7:0]                   reply_byte;
  logic                         frame_to;
  logic [7:0]                   mx;
  logic [NUM_SERVO-1:0][POS_LEN-1:0] pos_ch;

  assign pos = pos_ch;

  // Ranging reply image: AE, meas_len MSB-first, XOR of everything before.
  always_comb begin
    mbuf    = '0;
    mbuf[0] = 8'hAE;
    mx      = 8'hAE;
    for (int i = 0; i < CAP_BYTES; i++) begin
      mbuf[i+1] = meas_len[CAP_LEN-1-8*i -: 8];
      mx        = mx ^ meas_len[CAP_LEN-1-8*i -: 8];
    end
    mbuf[REPLY_N-1] = mx;
  end

  // Inter-byte timeout. It outranks a byte arriving in the same cycle.
  assign frame_to = (cnt == FRAME_TO_C);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    csum_nxt      = csum;
    ch_nxt        = ch;
    val_nxt       = val;
    vcnt_nxt      = vcnt;
    rbuf_nxt      = rbuf;
    idx_nxt       = idx;
    rem_nxt       = rem;
    skip_nxt      = skip;
    tx_data_nxt   = tx_data;
    tx_send_nxt   = 1'b0;
    meas_en_nxt   = 1'b0;
    frame_err_nxt = 1'b0;
    init_all      = 1'b0;
    wr_srv        = 1'b0;
    reply_one     = 1'b0;
    reply_byte    = 8'h00;

    case (state)
      BOOT: begin
        reply_one  = 1'b1;
        reply_byte = 8'hAA;
        state_nxt  = TX_LOAD;
      end
      IDLE: if (rx_valid) begin
        cnt_nxt = '0;
        case (rx_data)
          8'h00: begin
            init_all   = 1'b1;
            reply_one  = 1'b1;
            reply_byte = 8'hAA;
            state_nxt  = TX_LOAD;
          end
          8'h03: begin
            csum_nxt  = 8'h03;
            state_nxt = SRV_CH;
          end
          8'h0C:   state_nxt = MEAS_TRIG;
          default: state_nxt = NACK;
        endcase
      end
      SRV_CH: begin
        if (frame_to) state_nxt = NACK;
        else if (rx_valid) begin
          ch_nxt    = rx_data;
          csum_nxt  = csum ^ rx_data;
          cnt_nxt   = '0;
          vcnt_nxt  = '0;
          state_nxt = SRV_VAL;
        end else cnt_nxt = cnt + TO_LEN'(1);
      end
      SRV_VAL: begin
        if (frame_to) state_nxt = NACK;
        else if (rx_valid) begin
          val_nxt  = VAL_W'({val, rx_data});
          csum_nxt = csum ^ rx_data;
          cnt_nxt  = '0;
          if (vcnt == VLAST) state_nxt = SRV_SUM;
          else               vcnt_nxt  = vcnt + VW'(1);
        end else cnt_nxt = cnt + TO_LEN'(1);
      end
      SRV_SUM: begin
        if (frame_to) state_nxt = NACK;
        else if (rx_valid) begin
          cnt_nxt = '0;
          if (rx_data == csum && ch < NS8) begin
            wr_srv     = 1'b1;
            reply_one  = 1'b1;
            reply_byte = 8'hAB;
            state_nxt  = TX_LOAD;
          end else state_nxt = NACK;
        end else cnt_nxt = cnt + TO_LEN'(1);
      end
      MEAS_TRIG: begin
        meas_en_nxt = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = MEAS_WAIT;
      end
      MEAS_WAIT: begin
        if (meas_done) begin
          rbuf_nxt  = mbuf;
          idx_nxt   = '0;
          rem_nxt   = RW'(REPLY_N);
          state_nxt = TX_LOAD;
        end else if (cnt == MEAS_TO_C) begin
          // Ranging timeout is a normal outcome, not a protocol error.
          reply_one  = 1'b1;
          reply_byte = 8'hEF;
          state_nxt  = TX_LOAD;
        end else cnt_nxt = cnt + TO_LEN'(1);
      end
      NACK: begin
        frame_err_nxt = 1'b1;
        reply_one     = 1'b1;
        reply_byte    = 8'hEE;
        state_nxt     = TX_LOAD;
      end
      TX_LOAD: if (!tx_busy) begin
        tx_data_nxt = rbuf[idx];
        tx_send_nxt = 1'b1;
        skip_nxt    = 1'b1;
        state_nxt   = TX_WAIT;
      end
      TX_WAIT: begin
        // The first cycle is skipped because tx_busy may lag tx_send by one cycle.
        if (skip) skip_nxt = 1'b0;
        else if (!tx_busy) begin
          if (rem == RW'(1)) state_nxt = IDLE;
          else begin
            rem_nxt   = rem - RW'(1);
            idx_nxt   = idx + IW'(1);
            state_nxt = TX_LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (reply_one) begin
      rbuf_nxt[0] = reply_byte;
      idx_nxt     = '0;
      rem_nxt     = RW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state     <= BOOT;
      cnt       <= '0;
      csum      <= '0;
      ch        <= '0;
      val       <= '0;
      vcnt      <= '0;
      rbuf      <= '0;
      idx       <= '0;
      rem       <= '0;
      skip      <= 1'b0;
      tx_data   <= '0;
      tx_send   <= 1'b0;
      meas_en   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      csum      <= csum_nxt;
      ch        <= ch_nxt;
      val       <= val_nxt;
      vcnt      <= vcnt_nxt;
      rbuf      <= rbuf_nxt;
      idx       <= idx_nxt;
      rem       <= rem_nxt;
      skip      <= skip_nxt;
      tx_data   <= tx_data_nxt;
      tx_send   <= tx_send_nxt;
      meas_en   <= meas_en_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  for (genvar k = 0; k < NUM_SERVO; k++) begin : g_ch
    udar_ctrl_mc_ch #(
      .POS_LEN   (POS_LEN),
      .POS_RESET (POS_RESET)
    ) u_ch (
      .clk    (clk),
      .rst_i  (rst_i),
      .init   (init_all),
      .wr_en  (wr_srv && (ch == 8'(k))),
      .wr_val (val[POS_LEN-1:0]),
      .pos    (pos_ch[k])
    );
  end
endmodule

// File: tb/tb_udar_ctrl_mc.sv
module tb_udar_ctrl_mc;
  localparam int NS = 4, PL = 8, PR = 150, CL = 16;
  localparam int FTO = 200, MTO = 1000;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_send;
  logic          tx_busy;
  logic [NS*PL-1:0] pos;
  logic          meas_en;
  logic          meas_done = 1'b0;
  logic [CL-1:0] meas_len = '0;
  logic          frame_err;

  udar_ctrl_mc #(
    .NUM_SERVO(NS), .POS_LEN(PL), .POS_RESET(PR), .CAP_LEN(CL),
    .FRAME_TO(FTO), .MEAS_TO(MTO), .TO_LEN(22)
  ) dut (
    .clk(clk), .rst_i(rst_i), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy), .pos(pos),
    .meas_en(meas_en), .meas_done(meas_done), .meas_len(meas_len),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;
  int cyc = 0, busy_cnt = 0, fe_cnt = 0, men_cnt = 0, last_send_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_pos[NS];

  // Transmitter model: busy for 8 cycles, rising the cycle after tx_send.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_send) busy_cnt <= 8;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Scoreboard: every transmitted byte must be the next expected one,
  // and must not be sent while the transmitter is busy.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (meas_en) men_cnt++;
    if (!rst_i && tx_send) begin
      last_send_cyc = cyc;
      n_tot++;
      if (exp_q.size() == 0) $display("FAIL tx_unexpected: got %02h, required no send", tx_data);
      else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) $display("FAIL tx_byte: got %02h, required %02h", tx_data, e);
        else n_pass++;
      end
      n_tot++;
      if (tx_busy !== 1'b0) $display("FAIL tx_while_busy: tx_busy %b, required 0", tx_busy);
      else n_pass++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Waits for the expected reply queue to empty, then lets the reply engine
  // finish its busy wait so the DUT is back in IDLE.
  task automatic wait_drain(input int budget, output bit ok);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(posedge clk); n++; end
    ok = (exp_q.size() == 0);
    exp_q.delete();
    repeat (14) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int fe0;
    bit ok;
    repeat (3) @(posedge clk); #1;
    for (int k = 0; k < NS; k++) begin
      n_tot++;
      if (pos[k*PL +: PL] !== 8'(PR)) $display("FAIL reset_pos%0d: got %0d, required %0d", k, pos[k*PL +: PL], PR);
      else n_pass++;
      exp_pos[k] = 8'(PR);
    end
    n_tot++;
    if ({tx_data, tx_send, meas_en, frame_err} !== 11'h0)
      $display("FAIL reset_outs: got %03h, required 000", {tx_data, tx_send, meas_en, frame_err});
    else n_pass++;
    fe0 = fe_cnt;
    exp_q.push_back(8'hAA);
    rst_i = 1'b0;
    wait_drain(200, ok);
    n_tot++;
    if (!ok) $display("FAIL boot_reply: timed out, required AA");
    else n_pass++;
    n_tot++;
    if (fe_cnt != fe0) $display("FAIL boot_frame_err: got %0d pulses, required 0", fe_cnt - fe0);
    else n_pass++;
  endtask

  task automatic srv_frame(input string nm, input logic [7:0] c, input logic [7:0] v,
                           input logic [7:0] s, input bit good);
    int fe0;
    bit ok;
    fe0 = fe_cnt;
    exp_q.push_back(good ? 8'hAB : 8'hEE);
    send_byte(8'h03); send_byte(c); send_byte(v);
    if (good) begin
      n_tot++;
      if (pos[c*PL +: PL] !== exp_pos[c]) $display("FAIL %s_early: got %02h, required %02h", nm, pos[c*PL +: PL], exp_pos[c]);
      else n_pass++;
    end
    send_byte(s);
    if (good) begin
      exp_pos[c] = v;
      n_tot++;
      if (pos[c*PL +: PL] !== v) $display("FAIL %s_update: got %02h, required %02h", nm, pos[c*PL +: PL], v);
      else n_pass++;
    end
    wait_drain(200, ok);
    n_tot++;
    if (!ok) $display("FAIL %s_reply: timed out, required %02h", nm, good ? 8'hAB : 8'hEE);
    else n_pass++;
    n_tot++;
    if (fe_cnt - fe0 != (good ? 0 : 1)) $display("FAIL %s_frame_err: got %0d pulses, required %0d", nm, fe_cnt - fe0, good ? 0 : 1);
    else n_pass++;
    for (int k = 0; k < NS; k++) begin
      n_tot++;
      if (pos[k*PL +: PL] !== exp_pos[k]) $display("FAIL %s_pos%0d: got %02h, required %02h", nm, k, pos[k*PL +: PL], exp_pos[k]);
      else n_pass++;
    end
  endtask

  task automatic test_servo_write;
    srv_frame("wr_ch2", 8'd2, 8'h5A, 8'h03 ^ 8'd2 ^ 8'h5A, 1'b1);
    srv_frame("wr_ch0", 8'd0, 8'h11, 8'h03 ^ 8'd0 ^ 8'h11, 1'b1);
    srv_frame("wr_ch3", 8'd3, 8'hFF, 8'h03 ^ 8'd3 ^ 8'hFF, 1'b1);
  endtask

  task automatic test_nack;
    bit ok;
    int fe0;
    srv_frame("bad_sum", 8'd2, 8'h5A, 8'h00, 1'b0);
    srv_frame("bad_ch", 8'd7, 8'h10, 8'h03 ^ 8'd7 ^ 8'h10, 1'b0);
    srv_frame("ch_edge", 8'd4, 8'h22, 8'h03 ^ 8'd4 ^ 8'h22, 1'b0);
    fe0 = fe_cnt;
    exp_q.push_back(8'hEE);
    send_byte(8'h55);
    wait_drain(200, ok);
    n_tot++;
    if (!ok || fe_cnt - fe0 != 1) $display("FAIL bad_opcode: drained %0d, %0d pulses, required 1 and 1", ok, fe_cnt - fe0);
    else n_pass++;
  endtask

  task automatic test_frame_timeout;
    int t0, fe0, d;
    bit ok;
    fe0 = fe_cnt;
    exp_q.push_back(8'hEE);
    send_byte(8'h03); send_byte(8'h01);
    t0 = cyc;
    wait_drain(FTO + 100, ok);
    d = last_send_cyc - t0;
    n_tot++;
    if (!ok || d < FTO || d > FTO + 4) $display("FAIL frame_to: drained %0d after %0d cycles, required 1 in %0d..%0d", ok, d, FTO, FTO + 4);
    else n_pass++;
    n_tot++;
    if (fe_cnt - fe0 != 1) $display("FAIL frame_to_err: got %0d pulses, required 1", fe_cnt - fe0);
    else n_pass++;
    exp_q.push_back(8'hAA);
    send_byte(8'h00);
    wait_drain(200, ok);
    n_tot++;
    if (!ok) $display("FAIL init_reply: timed out, required AA");
    else n_pass++;
    for (int k = 0; k < NS; k++) begin
      exp_pos[k] = 8'(PR);
      n_tot++;
      if (pos[k*PL +: PL] !== 8'(PR)) $display("FAIL init_pos%0d: got %0d, required %0d", k, pos[k*PL +: PL], PR);
      else n_pass++;
    end
  endtask

  task automatic test_meas;
    int m0, fe0, n;
    bit ok;
    logic [7:0] x;
    m0 = men_cnt; fe0 = fe_cnt;
    send_byte(8'h0C);
    n = 0;
    while (men_cnt == m0 && n < 20) begin @(posedge clk); n++; end
    #1;
    n_tot++;
    if (men_cnt == m0) $display("FAIL meas_en: no pulse, required one");
    else n_pass++;
    x = 8'hAE ^ 8'h12 ^ 8'h34;
    exp_q.push_back(8'hAE); exp_q.push_back(8'h12);
    exp_q.push_back(8'h34); exp_q.push_back(x);
    repeat (300) @(posedge clk); #1;
    meas_len = 16'h1234; meas_done = 1'b1;
    @(posedge clk); #1;
    meas_done = 1'b0;
    wait_drain(400, ok);
    n_tot++;
    if (!ok) $display("FAIL meas_reply: %0d bytes missing, required 0", exp_q.size());
    else n_pass++;
    n_tot++;
    if (men_cnt - m0 != 1 || fe_cnt != fe0) $display("FAIL meas_pulses: meas_en %0d frame_err %0d, required 1 and 0", men_cnt - m0, fe_cnt - fe0);
    else n_pass++;
  endtask

  task automatic test_meas_timeout_reset;
    int t0, fe0, d, n;
    bit ok;
    srv_frame("pre_ch0", 8'd0, 8'h11, 8'h03 ^ 8'd0 ^ 8'h11, 1'b1);
    fe0 = fe_cnt;
    exp_q.push_back(8'hEF);
    send_byte(8'h0C);
    t0 = cyc;
    n = 0;
    while (exp_q.size() != 0 && n < MTO + 100) begin @(negedge clk); n++; end
    d = last_send_cyc - t0;
    n_tot++;
    if (exp_q.size() != 0 || d < MTO || d > MTO + 5) $display("FAIL meas_to: %0d left after %0d cycles, required 0 in %0d..%0d", exp_q.size(), d, MTO, MTO + 5);
    else n_pass++;
    exp_q.delete();
    // Injected while the reply is on the wire: must be dropped (an accepted
    // 00 would re-init channel 0 at once).
    send_byte(8'h00);
    n_tot++;
    if (pos[0 +: PL] !== 8'h11) $display("FAIL rx_drop: pos0 %02h, required 11", pos[0 +: PL]);
    else n_pass++;
    n_tot++;
    if (fe_cnt != fe0) $display("FAIL meas_to_err: got %0d pulses, required 0", fe_cnt - fe0);
    else n_pass++;
    rst_i = 1'b1;
    #1;
    n_tot++;
    if (tx_send !== 1'b0 || pos[0 +: PL] !== 8'(PR)) $display("FAIL mid_reset: tx_send %b pos0 %0d, required 0 and %0d", tx_send, pos[0 +: PL], PR);
    else n_pass++;
    repeat (3) @(posedge clk); #1;
    exp_q.push_back(8'hAA);
    rst_i = 1'b0;
    wait_drain(200, ok);
    n_tot++;
    if (!ok) $display("FAIL reboot_reply: timed out, required AA");
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_servo_write;
    test_nack;
    test_frame_timeout;
    test_meas;
    test_meas_timeout_reset;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
